dmi_abstract_initiator: RTL and testbench

- DMI initiator (requester side of the debug-module DMI link): turns one abstract register-access request from a local controller into the full DMI transaction sequence.
- Sequence: optional Data0 write, Command write, AbstractCS busy polling, error clear, and Data0 readback.
- Sits between a host-side controller (test sequencer, boot/debug mailbox) and the debug module's DMI request/response ports, in place of a JTAG DTM.
- Uses the package's dmi_req_t, dmi_resp_t, abstractcs_t, ac_ar_cmd_t and dm_csr_e encodings.

---
 rtl/dmi_abstract_initiator.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_dmi_abstract_initiator.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_abstract_initiator.sv
// dmi_abstract_initiator: requester side of the debug-module DMI link.
// Turns one abstract register-access request into the DMI transaction
// sequence: optional Data0 write, Command write, AbstractCS busy polling,
// cmderr clear and Data0 readback.
// Optional feature macro: DMI_ABS_DMACTIVE_EN (writes DMControl.dmactive on
// the first accepted start after reset).
module dmi_abstract_initiator #(
  parameter int unsigned MaxPolls = 16,
  parameter int unsigned PollCntW = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        write_i,
  input  logic [15:0] regno_i,
  input  logic [2:0]  aarsize_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic [2:0]  cmderr_o,
  output logic        timeout_o,
  output logic        resp_err_o,
  output logic        dmi_req_valid_o,
  input  logic        dmi_req_ready_i,
  output logic [40:0] dmi_req_o,
  input  logic        dmi_resp_valid_i,
  output logic        dmi_resp_ready_o,
  input  logic [33:0] dmi_resp_i
);

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  localparam logic [1:0] DTM_SUCCESS = 2'h0;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  typedef enum logic [6:0] {
    Data0      = 7'h04,
    DMControl  = 7'h10,
    AbstractCS = 7'h16,
    Command    = 7'h17
  } dm_csr_e;

  typedef enum logic [2:0] {
    CmdErrNone    = 3'h0,
    CmdErrorOther = 3'h7
  } cmderr_e;

  typedef struct packed {
    logic [2:0]  zero3;
    logic [4:0]  progbufsize;
    logic [10:0] zero2;
    logic        busy;
    logic        zero1;
    logic [2:0]  cmderr;
    logic [3:0]  zero0;
    logic [3:0]  datacount;
  } abstractcs_t;

  typedef struct packed {
    logic [7:0]  cmdtype;
    logic        zero1;
    logic [2:0]  aarsize;
    logic        aarpostincrement;
    logic        postexec;
    logic        transfer;
    logic        write;
    logic [15:0] regno;
  } ac_ar_cmd_t;

  // Bit positions of the AbstractCS fields inspected in a poll response
  localparam int unsigned CsBusyBit    = 12;
  localparam int unsigned CsCmdErrLsb  = 8;

  typedef enum logic [2:0] {
    IDLE,
`ifdef DMI_ABS_DMACTIVE_EN
    ACTIVATE,
`endif
    WR_DATA,
    WR_CMD,
    RD_CS,
    CLR_ERR,
    RD_DATA,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic                phase_q, phase_d;       // 0: request phase, 1: response phase
  logic [PollCntW-1:0] poll_cnt_q, poll_cnt_d;
  logic [PollCntW-1:0] poll_cnt_inc;
  logic [31:0]         rdata_q, rdata_d;
  logic [2:0]          cmderr_q, cmderr_d;
  logic                timeout_q, timeout_d;
  logic                resp_err_q, resp_err_d;
  logic                write_q, write_d;
  logic [15:0]         regno_q, regno_d;
  logic [2:0]          aarsize_q, aarsize_d;
  logic [31:0]         wdata_q, wdata_d;
`ifdef DMI_ABS_DMACTIVE_EN
  logic                activated_q, activated_d;
`endif

  dmi_req_t    req_s;
  dmi_resp_t   resp_s;
  ac_ar_cmd_t  cmd_s;
  abstractcs_t clr_s;
  logic [2:0]  resp_cmderr;

  assign resp_s       = dmi_resp_t'(dmi_resp_i);
  assign resp_cmderr  = resp_s.data[CsCmdErrLsb +: 3];
  assign poll_cnt_inc = poll_cnt_q + 1'b1;

  // Request word driven for the current state; stays stable through the request phase
  always_comb begin
    cmd_s          = '0;
    cmd_s.aarsize  = aarsize_q;
    cmd_s.transfer = 1'b1;
    cmd_s.write    = write_q;
    cmd_s.regno    = regno_q;
    clr_s          = '0;
    clr_s.cmderr   = 3'b111;
    req_s          = '{addr: 7'h00, op: DTM_NOP, data: 32'h0};
    case (state_q)
`ifdef DMI_ABS_DMACTIVE_EN
      ACTIVATE: req_s = '{addr: DMControl, op: DTM_WRITE, data: 32'h0000_0001};
`endif
      WR_DATA:  req_s = '{addr: Data0,      op: DTM_WRITE, data: wdata_q};
      WR_CMD:   req_s = '{addr: Command,    op: DTM_WRITE, data: cmd_s};
      RD_CS:    req_s = '{addr: AbstractCS, op: DTM_READ,  data: 32'h0};
      CLR_ERR:  req_s = '{addr: AbstractCS, op: DTM_WRITE, data: clr_s};
      RD_DATA:  req_s = '{addr: Data0,      op: DTM_READ,  data: 32'h0};
      default:  req_s = '{addr: 7'h00,      op: DTM_NOP,   data: 32'h0};
    endcase
  end

  // Next-state, handshake and result-flag logic
  always_comb begin
    state_d          = state_q;
    phase_d          = phase_q;
    poll_cnt_d       = poll_cnt_q;
    rdata_d          = rdata_q;
    cmderr_d         = cmderr_q;
    timeout_d        = timeout_q;
    resp_err_d       = resp_err_q;
    write_d          = write_q;
    regno_d          = regno_q;
    aarsize_d        = aarsize_q;
    wdata_d          = wdata_q;
`ifdef DMI_ABS_DMACTIVE_EN
    activated_d      = activated_q;
`endif
    dmi_req_valid_o  = 1'b0;
    dmi_resp_ready_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          write_d    = write_i;
          regno_d    = regno_i;
          aarsize_d  = aarsize_i;
          wdata_d    = wdata_i;
          cmderr_d   = CmdErrNone;
          timeout_d  = 1'b0;
          resp_err_d = 1'b0;
          phase_d    = 1'b0;
          state_d    = write_i ? WR_DATA : WR_CMD;
`ifdef DMI_ABS_DMACTIVE_EN
          if (!activated_q) state_d = ACTIVATE;
`endif
        end
      end

      DONE: state_d = IDLE;

      default: begin
        if (!phase_q) begin
          dmi_req_valid_o = 1'b1;
          if (dmi_req_ready_i) phase_d = 1'b1;
        end else begin
          dmi_resp_ready_o = 1'b1;
          if (dmi_resp_valid_i) begin
            phase_d = 1'b0;
            if (resp_s.resp != DTM_SUCCESS) begin
              // Any failed DMI access aborts; keep an already latched cmderr
              resp_err_d = 1'b1;
              if (cmderr_q == CmdErrNone) cmderr_d = CmdErrorOther;
              state_d = DONE;
            end else begin
              case (state_q)
`ifdef DMI_ABS_DMACTIVE_EN
                ACTIVATE: begin
                  activated_d = 1'b1;
                  state_d     = write_q ? WR_DATA : WR_CMD;
                end
`endif
                WR_DATA: state_d = WR_CMD;
                WR_CMD: begin
                  poll_cnt_d = '0;
                  state_d    = RD_CS;
                end
                RD_CS: begin
                  poll_cnt_d = poll_cnt_inc;
                  if (resp_s.data[CsBusyBit]) begin
                    if (poll_cnt_inc >= PollCntW'(MaxPolls)) begin
                      timeout_d = 1'b1;
                      cmderr_d  = CmdErrorOther;
                      state_d   = DONE;
                    end
                  end else if (resp_cmderr != CmdErrNone) begin
                    cmderr_d = resp_cmderr;
                    state_d  = CLR_ERR;
                  end else begin
                    state_d = write_q ? DONE : RD_DATA;
                  end
                end
                RD_DATA: begin
                  rdata_d = resp_s.data;
                  state_d = DONE;
                end
                default: state_d = DONE;
              endcase
            end
          end
        end
      end
    endcase
  end

  // Control and result registers, cleared by synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      poll_cnt_q  <= '0;
      rdata_q     <= '0;
      cmderr_q    <= '0;
      timeout_q   <= 1'b0;
      resp_err_q  <= 1'b0;
`ifdef DMI_ABS_DMACTIVE_EN
      activated_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      poll_cnt_q  <= poll_cnt_d;
      rdata_q     <= rdata_d;
      cmderr_q    <= cmderr_d;
      timeout_q   <= timeout_d;
      resp_err_q  <= resp_err_d;
`ifdef DMI_ABS_DMACTIVE_EN
      activated_q <= activated_d;
`endif
    end
  end

  // Request operands captured at start; only consumed while busy, so no reset
  always_ff @(posedge clk_i) begin
    write_q   <= write_d;
    regno_q   <= regno_d;
    aarsize_q <= aarsize_d;
    wdata_q   <= wdata_d;
  end

  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);
  assign rdata_o    = rdata_q;
  assign cmderr_o   = cmderr_q;
  assign timeout_o  = timeout_q;
  assign resp_err_o = resp_err_q;
  assign dmi_req_o  = req_s;

endmodule

// File: tb/tb_dmi_abstract_initiator.sv
// Directed bench for dmi_abstract_initiator; the bench plays the debug module.
// Honours DMI_ABS_DMACTIVE_EN by expecting the DMControl write where required.
module tb_dmi_abstract_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        write;
  logic [15:0] regno;
  logic [2:0]  aarsize;
  logic [31:0] wdata;
  logic        busy_o, done_o, timeout_o, resp_err_o;
  logic [31:0] rdata_o;
  logic [2:0]  cmderr_o;
  logic        dmi_req_valid_o, dmi_req_ready_i;
  logic [40:0] dmi_req_o;
  logic        dmi_resp_valid_i, dmi_resp_ready_o;
  logic [33:0] dmi_resp_i;

  int n_asserts = 0;
  int n_fail    = 0;

  localparam logic [1:0] OP_RD = 2'd1;
  localparam logic [1:0] OP_WR = 2'd2;

  always #5 clk = ~clk;

  dmi_abstract_initiator #(.MaxPolls(16), .PollCntW(5)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .start_i          (start),
    .write_i          (write),
    .regno_i          (regno),
    .aarsize_i        (aarsize),
    .wdata_i          (wdata),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .rdata_o          (rdata_o),
    .cmderr_o         (cmderr_o),
    .timeout_o        (timeout_o),
    .resp_err_o       (resp_err_o),
    .dmi_req_valid_o  (dmi_req_valid_o),
    .dmi_req_ready_i  (dmi_req_ready_i),
    .dmi_req_o        (dmi_req_o),
    .dmi_resp_valid_i (dmi_resp_valid_i),
    .dmi_resp_ready_o (dmi_resp_ready_o),
    .dmi_resp_i       (dmi_resp_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One DM-side transaction: expect the request, optionally stall, then respond
  task automatic dm_txn(input string tag, input logic [6:0] addr, input logic [1:0] op,
                        input logic [31:0] data, input int stall,
                        input logic [31:0] rd, input logic [1:0] resp);
    int t;
    t = 0;
    while (dmi_req_valid_o !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_valid"}, dmi_req_valid_o, 1'b1);
    chk({tag, "_req"}, dmi_req_o, {addr, op, data});
    for (int i = 0; i < stall; i++) begin
      // A stray response while in request phase must be ignored
      dmi_resp_valid_i = 1'b1;
      dmi_resp_i       = {32'hFFFF_FFFF, 2'b10};
      @(negedge clk);
      chk({tag, "_hold"}, {dmi_req_valid_o, dmi_resp_ready_o, dmi_req_o},
          {1'b1, 1'b0, addr, op, data});
    end
    dmi_resp_valid_i = 1'b0;
    dmi_resp_i       = '0;
    dmi_req_ready_i  = 1'b1;
    @(negedge clk);
    dmi_req_ready_i  = 1'b0;
    chk({tag, "_rsprdy"}, {dmi_req_valid_o, dmi_resp_ready_o}, 2'b01);
    dmi_resp_valid_i = 1'b1;
    dmi_resp_i       = {rd, resp};
    @(negedge clk);
    dmi_resp_valid_i = 1'b0;
    dmi_resp_i       = '0;
  endtask

  // Pulse start, then scramble the inputs to prove they were captured
  task automatic do_start(input string tag, input logic w, input logic [15:0] rg,
                          input logic [2:0] sz, input logic [31:0] wd);
    start   = 1'b1;
    write   = w;
    regno   = rg;
    aarsize = sz;
    wdata   = wd;
    @(negedge clk);
    start   = 1'b0;
    write   = ~w;
    regno   = 16'hFFFF;
    aarsize = 3'h7;
    wdata   = 32'hBAD0_BAD0;
    chk({tag, "_busy"}, {busy_o, done_o}, 2'b10);
    chk({tag, "_flags_clr"}, {cmderr_o, timeout_o, resp_err_o}, 5'b0);
  endtask

  // DONE must follow immediately; start held in DONE must not be accepted
  task automatic expect_done(input string tag);
    chk({tag, "_done"}, {done_o, busy_o, dmi_req_valid_o}, 3'b110);
    start = 1'b1;
    write = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_idle"}, {done_o, busy_o, dmi_req_valid_o}, 3'b000);
  endtask

  task automatic expect_activate(input string tag);
`ifdef DMI_ABS_DMACTIVE_EN
    dm_txn({tag, "_act"}, 7'h10, OP_WR, 32'h0000_0001, 0, 32'h0, 2'b00);
`else
    chk({tag, "_noact"}, dmi_req_o[40:34], 7'h17);
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; write = 1'b0; regno = '0; aarsize = '0; wdata = '0;
    dmi_req_ready_i = 1'b0; dmi_resp_valid_i = 1'b0; dmi_resp_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {busy_o, done_o, dmi_req_valid_o, dmi_resp_ready_o}, 4'b0);
    chk("rst_req", dmi_req_o, 41'h0);
    chk("rst_res", {rdata_o, cmderr_o, timeout_o, resp_err_o}, 37'h0);
    rst = 1'b0;
    @(negedge clk);

    // Read with two busy polls
    do_start("t1", 1'b0, 16'h1008, 3'd2, 32'h0);
    expect_activate("t1");
    dm_txn("t1_cmd", 7'h17, OP_WR, 32'h0022_1008, 0, 32'h0, 2'b00);
    dm_txn("t1_cs0", 7'h16, OP_RD, 32'h0, 0, 32'h0000_1000, 2'b00);
    start = 1'b1; write = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dm_txn("t1_cs1", 7'h16, OP_RD, 32'h0, 0, 32'h0000_1000, 2'b00);
    dm_txn("t1_cs2", 7'h16, OP_RD, 32'h0, 0, 32'h0000_0002, 2'b00);
    dm_txn("t1_d0", 7'h04, OP_RD, 32'h0, 0, 32'hDEAD_BEEF, 2'b00);
    expect_done("t1");
    chk("t1_rdata", rdata_o, 32'hDEAD_BEEF);
    chk("t1_flags", {cmderr_o, timeout_o, resp_err_o}, 5'b0);

    // Write with 5 cycles of request backpressure on the Data0 write
    do_start("t2", 1'b1, 16'h1001, 3'd2, 32'h1234_5678);
    dm_txn("t2_d0", 7'h04, OP_WR, 32'h1234_5678, 5, 32'h0, 2'b00);
    dm_txn("t2_cmd", 7'h17, OP_WR, 32'h0023_1001, 0, 32'h0, 2'b00);
    dm_txn("t2_cs", 7'h16, OP_RD, 32'h0, 0, 32'h0, 2'b00);
    expect_done("t2");
    chk("t2_rdata", rdata_o, 32'hDEAD_BEEF);
    chk("t2_flags", {cmderr_o, timeout_o, resp_err_o}, 5'b0);

    // Command error reported by AbstractCS
    do_start("t3", 1'b0, 16'h1008, 3'd2, 32'h0);
    dm_txn("t3_cmd", 7'h17, OP_WR, 32'h0022_1008, 0, 32'h0, 2'b00);
    dm_txn("t3_cs", 7'h16, OP_RD, 32'h0, 0, 32'h0000_0300, 2'b00);
    dm_txn("t3_clr", 7'h16, OP_WR, 32'h0000_0700, 0, 32'h0, 2'b00);
    expect_done("t3");
    chk("t3_cmderr", cmderr_o, 3'd3);
    chk("t3_rdata", rdata_o, 32'hDEAD_BEEF);
    chk("t3_to", {timeout_o, resp_err_o}, 2'b00);

    // Poll timeout: exactly 16 AbstractCS reads, no clear
    do_start("t4", 1'b0, 16'h2000, 3'd3, 32'h0);
    dm_txn("t4_cmd", 7'h17, OP_WR, 32'h0032_2000, 0, 32'h0, 2'b00);
    for (int i = 0; i < 16; i++)
      dm_txn("t4_cs", 7'h16, OP_RD, 32'h0, 0, 32'h0000_1000, 2'b00);
    expect_done("t4");
    chk("t4_res", {cmderr_o, timeout_o, resp_err_o}, {3'd7, 1'b1, 1'b0});

    // DMI error response on the Command write
    do_start("t5", 1'b0, 16'h1008, 3'd2, 32'h0);
    dm_txn("t5_cmd", 7'h17, OP_WR, 32'h0022_1008, 0, 32'h0, 2'b10);
    expect_done("t5");
    chk("t5_res", {cmderr_o, timeout_o, resp_err_o}, {3'd7, 1'b0, 1'b1});

    // Reset while waiting for an AbstractCS response
    do_start("t6", 1'b0, 16'h1008, 3'd2, 32'h0);
    dm_txn("t6_cmd", 7'h17, OP_WR, 32'h0022_1008, 0, 32'h0, 2'b00);
    chk("t6_csreq", {dmi_req_valid_o, dmi_req_o}, {1'b1, 7'h16, OP_RD, 32'h0});
    dmi_req_ready_i = 1'b1;
    @(negedge clk);
    dmi_req_ready_i = 1'b0;
    chk("t6_rsprdy", dmi_resp_ready_o, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_ctrl", {busy_o, done_o, dmi_req_valid_o, dmi_resp_ready_o}, 4'b0);
    chk("t6_req", dmi_req_o, 41'h0);
    chk("t6_res", {rdata_o, cmderr_o, timeout_o, resp_err_o}, 37'h0);
    // Late response after reset must be ignored
    dmi_resp_valid_i = 1'b1;
    dmi_resp_i       = {32'h0000_1000, 2'b00};
    @(negedge clk);
    dmi_resp_valid_i = 1'b0;
    dmi_resp_i       = '0;
    chk("t6_late", {busy_o, dmi_resp_ready_o, resp_err_o}, 3'b000);

    // Fresh read after reset
    do_start("t7", 1'b0, 16'h1010, 3'd2, 32'h0);
    expect_activate("t7");
    dm_txn("t7_cmd", 7'h17, OP_WR, 32'h0022_1010, 0, 32'h0, 2'b00);
    dm_txn("t7_cs", 7'h16, OP_RD, 32'h0, 0, 32'h0, 2'b00);
    dm_txn("t7_d0", 7'h04, OP_RD, 32'h0, 0, 32'hCAFE_F00D, 2'b00);
    expect_done("t7");
    chk("t7_rdata", rdata_o, 32'hCAFE_F00D);
    chk("t7_flags", {cmderr_o, timeout_o, resp_err_o}, 5'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
